idma_irq_coalescer: RTL and testbench

Interrupt coalescing stage downstream of the iDMA descriptor frontend's completion interrupt. It counts per-descriptor completion pulses and raises one level interrupt to the core's PLIC when a count threshold is reached, a timeout expires, or the DMA goes idle with completions pending. Software configures it and acknowledges interrupts through a regbus slave that sits next to the DMA's own register port.

---
 rtl/idma_irq_coal_pkg.sv | 53 +++++
 rtl/idma_irq_coal_regs.sv | 111 +++++++++++
 rtl/idma_irq_coalescer.sv | 127 ++++++++++++
 tb/tb_idma_irq_coalescer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_irq_coal_pkg.sv
// Shared definitions for the iDMA completion-interrupt coalescer: register map,
// CTRL/STATUS field positions, FSM state encoding and regbus payload types.
package idma_irq_coal_pkg;

    localparam int unsigned RegAddrWidth = 32;
    localparam int unsigned RegDataWidth = 64;
    localparam int unsigned RegStrbWidth = RegDataWidth / 8;

    localparam logic [RegAddrWidth-1:0] RegOffCtrl    = 32'h0000_0000;
    localparam logic [RegAddrWidth-1:0] RegOffTimeout = 32'h0000_0008;
    localparam logic [RegAddrWidth-1:0] RegOffStatus  = 32'h0000_0010;
    localparam logic [RegAddrWidth-1:0] RegOffAck     = 32'h0000_0018;

    localparam int unsigned CtrlEnBit        = 0;
    localparam int unsigned CtrlIdleFlushBit = 1;
    localparam int unsigned CtrlThreshLsb    = 8;

    localparam int unsigned StatusStateLsb = 29;
    localparam int unsigned StatusIrqBit   = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } coal_state_e;

    typedef struct packed {
        logic [RegAddrWidth-1:0] addr;
        logic                    write;
        logic [RegDataWidth-1:0] wdata;
        logic [RegStrbWidth-1:0] wstrb;
        logic                    valid;
    } coal_reg_req_t;

    typedef struct packed {
        logic [RegDataWidth-1:0] rdata;
        logic                    error;
        logic                    ready;
    } coal_reg_rsp_t;

    // Byte-lane merge of a 32-bit register write.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/idma_irq_coal_regs.sv
// Regbus slave of the interrupt coalescer: address decode, CTRL/TIMEOUT storage,
// STATUS readback and the single-cycle ACK strobe.
module idma_irq_coal_regs
    import idma_irq_coal_pkg::*;
#(
    parameter int unsigned CntWidth   = 8,
    parameter int unsigned TimerWidth = 24,
    parameter type         reg_req_t  = coal_reg_req_t,
    parameter type         reg_rsp_t  = coal_reg_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  reg_req_t              reg_req_i,
    output reg_rsp_t              reg_rsp_o,
    input  logic [CntWidth-1:0]   count_i,
    input  coal_state_e           state_i,
    input  logic                  irq_i,
    output logic                  en_o,
    output logic                  idle_flush_o,
    output logic [CntWidth-1:0]   thresh_o,
    output logic [TimerWidth-1:0] timeout_o,
    output logic                  ack_o
);

    logic                  en_q, en_d;
    logic                  flush_q, flush_d;
    logic [CntWidth-1:0]   thresh_q, thresh_d;
    logic [TimerWidth-1:0] timeout_q, timeout_d;

    logic        sel_ctrl, sel_timeout, sel_status, sel_ack, mapped, wr_en;
    logic [31:0] ctrl_rd, timeout_rd, status_rd, rd_word;
    logic [31:0] ctrl_wr, timeout_wr;
    logic        unused_bits;

    assign sel_ctrl    = (reg_req_i.addr == RegOffCtrl);
    assign sel_timeout = (reg_req_i.addr == RegOffTimeout);
    assign sel_status  = (reg_req_i.addr == RegOffStatus);
    assign sel_ack     = (reg_req_i.addr == RegOffAck);
    assign mapped      = sel_ctrl | sel_timeout | sel_status | sel_ack;
    assign wr_en       = reg_req_i.valid & reg_req_i.write;

    // Readback words; unused bits read as zero.
    always_comb begin
        ctrl_rd                              = '0;
        ctrl_rd[CtrlEnBit]                   = en_q;
        ctrl_rd[CtrlIdleFlushBit]            = flush_q;
        ctrl_rd[CtrlThreshLsb +: CntWidth]   = thresh_q;
        timeout_rd                           = '0;
        timeout_rd[TimerWidth-1:0]           = timeout_q;
        status_rd                            = '0;
        status_rd[CntWidth-1:0]              = count_i;
        status_rd[StatusStateLsb +: 2]       = state_i;
        status_rd[StatusIrqBit]              = irq_i;
    end

    always_comb begin
        rd_word = '0;
        if (sel_ctrl)         rd_word = ctrl_rd;
        else if (sel_timeout) rd_word = timeout_rd;
        else if (sel_status)  rd_word = status_rd;
    end

    assign ctrl_wr    = apply_wstrb(ctrl_rd, reg_req_i.wdata[31:0], reg_req_i.wstrb[3:0]);
    assign timeout_wr = apply_wstrb(timeout_rd, reg_req_i.wdata[31:0], reg_req_i.wstrb[3:0]);

    always_comb begin
        en_d      = en_q;
        flush_d   = flush_q;
        thresh_d  = thresh_q;
        timeout_d = timeout_q;
        if (wr_en && sel_ctrl) begin
            en_d     = ctrl_wr[CtrlEnBit];
            flush_d  = ctrl_wr[CtrlIdleFlushBit];
            thresh_d = ctrl_wr[CtrlThreshLsb +: CntWidth];
        end
        if (wr_en && sel_timeout) begin
            timeout_d = timeout_wr[TimerWidth-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q      <= 1'b0;
            flush_q   <= 1'b0;
            thresh_q  <= '0;
            timeout_q <= '0;
        end else begin
            en_q      <= en_d;
            flush_q   <= flush_d;
            thresh_q  <= thresh_d;
            timeout_q <= timeout_d;
        end
    end

    // Response is single-cycle: ready follows valid combinationally.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = reg_req_i.valid;
        reg_rsp_o.error = reg_req_i.valid & ~mapped;
        if (reg_req_i.valid) reg_rsp_o.rdata[31:0] = rd_word;
    end

    assign ack_o        = wr_en & sel_ack & reg_req_i.wstrb[0] & reg_req_i.wdata[0];
    assign en_o         = en_q;
    assign idle_flush_o = flush_q;
    assign thresh_o     = thresh_q;
    assign timeout_o    = timeout_q;

    assign unused_bits = ^{reg_req_i.wdata, reg_req_i.wstrb, ctrl_wr, timeout_wr};

endmodule

// File: rtl/idma_irq_coalescer.sv
// Coalesces per-descriptor iDMA completion pulses into one level interrupt,
// fired on count threshold, timeout, or idle flush; bypassed when EN=0.
module idma_irq_coalescer
    import idma_irq_coal_pkg::*;
#(
    parameter int unsigned CntWidth   = 8,
    parameter int unsigned TimerWidth = 24,
    parameter type         reg_req_t  = coal_reg_req_t,
    parameter type         reg_rsp_t  = coal_reg_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     done_i,
    input  logic     busy_i,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output logic     irq_o
);

    localparam int unsigned           TimerCmpWidth = TimerWidth + 1;
    localparam logic [CntWidth-1:0]   CntMax        = '1;
    localparam logic [TimerWidth-1:0] TimerMax      = '1;

    logic                  en, idle_flush, ack;
    logic [CntWidth-1:0]   thresh;
    logic [TimerWidth-1:0] timeout;

    coal_state_e           state_q, state_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic                  busy_q;
    logic                  irq_q, irq_d;

    logic [CntWidth-1:0] thresh_eff, count_inc, count_acc;
    logic                thresh_hit, timeout_hit, flush_hit;

    idma_irq_coal_regs #(
        .CntWidth   (CntWidth),
        .TimerWidth (TimerWidth),
        .reg_req_t  (reg_req_t),
        .reg_rsp_t  (reg_rsp_t)
    ) i_regs (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .reg_req_i    (reg_req_i),
        .reg_rsp_o    (reg_rsp_o),
        .count_i      (count_q),
        .state_i      (state_q),
        .irq_i        (irq_q),
        .en_o         (en),
        .idle_flush_o (idle_flush),
        .thresh_o     (thresh),
        .timeout_o    (timeout),
        .ack_o        (ack)
    );

    // Firing conditions look at the count including this cycle's completion.
    assign thresh_eff  = (thresh == '0) ? CntWidth'(1) : thresh;
    assign count_inc   = (count_q == CntMax) ? count_q : count_q + CntWidth'(1);
    assign count_acc   = done_i ? count_inc : count_q;
    assign thresh_hit  = (count_acc >= thresh_eff);
    // Timer is 0 in the cycle after the first completion, which itself counts as cycle 1.
    assign timeout_hit = (timeout != '0) &&
                         ((TimerCmpWidth'(timer_q) + TimerCmpWidth'(2)) >= TimerCmpWidth'(timeout));
    assign flush_hit   = idle_flush & busy_q & ~busy_i;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        if (!en) begin
            state_d = IDLE;
            count_d = '0;
            timer_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (done_i) begin
                        count_d = CntWidth'(1);
                        timer_d = '0;
                        state_d = (thresh_hit || (timeout == TimerWidth'(1))) ? FIRE : ACCUM;
                    end
                end
                ACCUM: begin
                    count_d = count_acc;
                    timer_d = (timer_q == TimerMax) ? timer_q : timer_q + TimerWidth'(1);
                    if (thresh_hit || timeout_hit || flush_hit) state_d = FIRE;
                end
                FIRE: begin
                    count_d = count_acc;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                    timer_d = '0;
                end
            endcase
            // ACK beats any firing in the same cycle; a racing completion starts a new batch.
            if (ack && (state_d == FIRE)) begin
                state_d = done_i ? ACCUM : IDLE;
                count_d = done_i ? CntWidth'(1) : '0;
                timer_d = '0;
            end
        end
    end

    assign irq_d = en ? (state_d == FIRE) : done_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            busy_q  <= busy_i;
            irq_q   <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_idma_irq_coalescer.sv
// Directed bench for idma_irq_coalescer; cycle numbers count posedges since the last reset.
module tb_idma_irq_coalescer;
    import idma_irq_coal_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          done_i;
    logic          busy_i;
    coal_reg_req_t reg_req_i;
    coal_reg_rsp_t reg_rsp_o;
    logic          irq_o;

    int cyc;
    int n_tests;
    int n_fail;

    always #5 clk_i = ~clk_i;

    idma_irq_coalescer dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .done_i    (done_i),
        .busy_i    (busy_i),
        .reg_req_i (reg_req_i),
        .reg_rsp_o (reg_rsp_o),
        .irq_o     (irq_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        cyc   = 0;
    endtask

    task automatic reg_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb);
        reg_req_i.addr  = addr;
        reg_req_i.write = 1'b1;
        reg_req_i.wdata = 64'(data);
        reg_req_i.wstrb = strb;
        reg_req_i.valid = 1'b1;
        tick();
        reg_req_i = '0;
    endtask

    task automatic reg_read(input logic [31:0] addr, output logic [63:0] data, output logic err);
        reg_req_i.addr  = addr;
        reg_req_i.write = 1'b0;
        reg_req_i.valid = 1'b1;
        #1;
        data = reg_rsp_o.rdata;
        err  = reg_rsp_o.error;
        reg_req_i = '0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] addr, input logic [63:0] exp);
        logic [63:0] d;
        logic        e;
        reg_read(addr, d, e);
        check_eq(tag, d, exp);
    endtask

    task automatic pulse_at(input int n);
        wait_cyc(n);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic        e;
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        rst_i     = 1'b0;
        done_i    = 1'b0;
        busy_i    = 1'b0;
        reg_req_i = '0;

        // Reset state
        do_reset();
        check_eq("rst_irq", irq_o, 0);
        check_eq("rst_ready", reg_rsp_o.ready, 0);
        check_eq("rst_error", reg_rsp_o.error, 0);
        check_eq("rst_rdata", reg_rsp_o.rdata, 0);
        check_reg("rst_ctrl", RegOffCtrl, 0);
        check_reg("rst_timeout", RegOffTimeout, 0);
        check_reg("rst_status", RegOffStatus, 0);

        // Bypass with reset configuration
        wait_cyc(10);
        check_eq("byp_pre", irq_o, 0);
        pulse_at(10);
        check_eq("byp_c11", irq_o, 1);
        tick();
        check_eq("byp_c12", irq_o, 0);
        check_reg("byp_status", RegOffStatus, 0);

        // Threshold = 4, then ACK
        do_reset();
        reg_write(RegOffCtrl, 32'h0000_0401, 8'hFF);
        pulse_at(20);
        pulse_at(22);
        pulse_at(24);
        wait_cyc(26);
        check_eq("thr_c26", irq_o, 0);
        pulse_at(26);
        check_eq("thr_c27", irq_o, 1);
        check_reg("thr_status", RegOffStatus, 64'hC000_0004);
        wait_cyc(40);
        check_eq("thr_c40", irq_o, 1);
        reg_write(RegOffAck, 32'h1, 8'hFF);
        check_eq("ack_c41", irq_o, 0);
        check_reg("ack_status", RegOffStatus, 0);

        // Timeout = 100, extra completions do not move the deadline
        do_reset();
        reg_write(RegOffCtrl, 32'h0000_1001, 8'hFF);
        reg_write(RegOffTimeout, 32'd100, 8'hFF);
        pulse_at(50);
        pulse_at(60);
        pulse_at(70);
        wait_cyc(149);
        check_eq("tmo_c149", irq_o, 0);
        tick();
        check_eq("tmo_c150", irq_o, 1);
        check_reg("tmo_status", RegOffStatus, 64'hC000_0003);

        // Idle flush on busy falling edge
        busy_i = 1'b1;
        do_reset();
        reg_write(RegOffCtrl, 32'h0000_1003, 8'hFF);
        pulse_at(10);
        pulse_at(12);
        pulse_at(14);
        wait_cyc(80);
        check_eq("fl_c80", irq_o, 0);
        check_reg("fl_accum", RegOffStatus, 64'h2000_0003);
        busy_i = 1'b0;
        tick();
        check_eq("fl_c81", irq_o, 1);
        check_reg("fl_status", RegOffStatus, 64'hC000_0003);

        // Lowering THRESH below the pending count fires one cycle after it lands
        do_reset();
        reg_write(RegOffCtrl, 32'h0000_1001, 8'hFF);
        pulse_at(5);
        pulse_at(6);
        pulse_at(7);
        wait_cyc(10);
        reg_write(RegOffCtrl, 32'h0000_0201, 8'hFF);
        check_eq("rcfg_c11", irq_o, 0);
        tick();
        check_eq("rcfg_c12", irq_o, 1);

        // ACK racing a completion with THRESH=1
        do_reset();
        reg_write(RegOffCtrl, 32'h0000_0101, 8'hFF);
        pulse_at(10);
        check_eq("race_fire", irq_o, 1);
        check_reg("race_st1", RegOffStatus, 64'hC000_0001);
        wait_cyc(20);
        done_i = 1'b1;
        reg_write(RegOffAck, 32'h1, 8'hFF);
        done_i = 1'b0;
        check_eq("race_c21", irq_o, 0);
        check_reg("race_st2", RegOffStatus, 64'h2000_0001);
        tick();
        check_eq("race_c22", irq_o, 1);

        // Saturation at 255
        do_reset();
        reg_write(RegOffCtrl, 32'h0000_FF01, 8'hFF);
        done_i = 1'b1;
        repeat (254) tick();
        check_eq("sat_254_irq", irq_o, 0);
        check_reg("sat_254", RegOffStatus, 64'h2000_00FE);
        tick();
        check_eq("sat_255_irq", irq_o, 1);
        repeat (300) tick();
        done_i = 1'b0;
        tick();
        check_reg("sat_cnt", RegOffStatus, 64'hC000_00FF);

        // Unmapped access, byte strobes, write-only ACK
        reg_read(32'h20, d, e);
        check_eq("unm_err", e, 1);
        check_eq("unm_rdata", d, 0);
        reg_write(32'h20, 32'hFFFF_FFFF, 8'hFF);
        check_reg("unm_noeff", RegOffCtrl, 64'h0000_FF01);
        reg_write(RegOffCtrl, 32'h0000_0500, 8'h02);
        check_reg("strb_ctrl", RegOffCtrl, 64'h0000_0501);
        reg_write(RegOffTimeout, 32'hAABB_CCDD, 8'h05);
        check_reg("strb_tmo", RegOffTimeout, 64'h00BB_00DD);
        reg_read(RegOffAck, d, e);
        check_eq("ack_rd", d, 0);
        check_eq("ack_rd_err", e, 0);

        // Clearing EN in FIRE
        reg_write(RegOffCtrl, 32'h0, 8'h01);
        tick();
        check_eq("en_off_irq", irq_o, 0);
        check_reg("en_off_st", RegOffStatus, 0);
        check_reg("en_off_ctrl", RegOffCtrl, 64'h0000_0500);

        // Reset in FIRE
        reg_write(RegOffCtrl, 32'h0000_0101, 8'hFF);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check_eq("mid_fire", irq_o, 1);
        do_reset();
        check_eq("mid_rst_irq", irq_o, 0);
        check_eq("mid_rst_ready", reg_rsp_o.ready, 0);
        check_reg("mid_rst_ctrl", RegOffCtrl, 0);
        check_reg("mid_rst_tmo", RegOffTimeout, 0);
        check_reg("mid_rst_st", RegOffStatus, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
